// File: rtl/if_stage_pkg.sv
// if_stage_pkg
//   Shared definitions for the instruction-fetch stage: fetch state
//   encoding, sequential PC step and instruction ROM address width.
//   Imported by if_stage.

package if_stage_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          IMEM_AW = 10;

  // Sequential successor of a PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_stat_counter.sv
// stat_counter
//   Free-running statistics counter with increment enable. Wraps modulo
//   2^CNT_W. Cleared by the asynchronous active-low reset.
// Ports
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous reset, active-low
//   inc    in   1      add one at the next rising edge
//   count  out  CNT_W  current value

module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage
//   Instruction-fetch stage in front of the IF/ID pipeline register.
//   Holds the PC, picks the next PC (sequential, branch, jump), drives the
//   instruction ROM address and hands PC+4 plus the fetched word to IF/ID.
//   A two-state fetch machine stops fetching on a syscall halt decoded in
//   ID and resumes on a go pulse. Three statistics counters track RUN
//   cycles, taken branches and jumps.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | fetching; PC advances, stalls or redirects every cycle
//   HALT  | syscall seen; PC, IF/ID and counters frozen until in_go
//
// Ports
//   in_CLK         in   1        clock, rising edge
//   in_RST_N       in   1        asynchronous reset, active-low
//   in_EN          in   1        fetch enable, 0 = load-use stall
//   in_br_taken    in   1        branch resolved taken (registered in EX)
//   in_br_target   in   32       branch target
//   in_jmp         in   1        jump / jr resolved (registered in EX)
//   in_jmp_target  in   32       jump target
//   in_halt        in   1        syscall halt decoded in ID
//   in_go          in   1        resume pulse while halted
//   out_imem_addr  out  IMEM_AW  ROM word address = PC[11:2]
//   in_imem_data   in   32       ROM data, combinational from address
//   out_pcout      out  32       PC+4 for IF/ID
//   out_is         out  32       fetched word for IF/ID
//   out_ifid_en    out  1        IF/ID load enable
//   out_ifid_clr   out  1        IF/ID flush of the wrong-path word
//   out_pc         out  32       current PC
//   out_halted     out  1        high while in HALT
//   out_cycle_cnt  out  CNT_W    RUN cycles elapsed
//   out_br_cnt     out  CNT_W    taken conditional branches
//   out_jmp_cnt    out  CNT_W    unconditional jumps

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic               in_CLK,
  input  logic               in_RST_N,
  input  logic               in_EN,
  input  logic               in_br_taken,
  input  logic [31:0]        in_br_target,
  input  logic               in_jmp,
  input  logic [31:0]        in_jmp_target,
  input  logic               in_halt,
  input  logic               in_go,
  output logic [IMEM_AW-1:0] out_imem_addr,
  input  logic [31:0]        in_imem_data,
  output logic [31:0]        out_pcout,
  output logic [31:0]        out_is,
  output logic               out_ifid_en,
  output logic               out_ifid_clr,
  output logic [31:0]        out_pc,
  output logic               out_halted,
  output logic [CNT_W-1:0]   out_cycle_cnt,
  output logic [CNT_W-1:0]   out_br_cnt,
  output logic [CNT_W-1:0]   out_jmp_cnt
);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic         running;
  logic         halt_live;

  assign pc_plus4 = seq_pc(pc);
  assign running  = (state == ST_RUN);
  // Both redirect sources come straight from EX registers, so the flush
  // can be driven combinationally without glitching.
  assign redirect = in_br_taken | in_jmp;
  // A halt decoded behind a redirect belongs to a squashed path.
  assign halt_live = in_halt & ~redirect;

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_RUN: begin
        // Redirect beats stall and halt; branch beats jump.
        if (in_br_taken) begin
          pc_next = in_br_target;
        end else if (in_jmp) begin
          pc_next = in_jmp_target;
        end else if (!in_EN || in_halt) begin
          pc_next = pc;
        end else begin
          pc_next = pc_plus4;
        end
        // A stalled halt waits until ID actually advances.
        if (halt_live && in_EN) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        // PC already points after the syscall, so fetch resumes there.
        if (in_go) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign out_imem_addr = pc[IMEM_AW+1:2];
  assign out_pcout     = pc_plus4;
  assign out_is        = in_imem_data;
  assign out_pc        = pc;
  assign out_halted    = (state == ST_HALT);
  assign out_ifid_clr  = redirect;
  assign out_ifid_en   = in_EN & running & ~halt_live;

  stat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (in_CLK),
    .rst_n (in_RST_N),
    .inc   (running),
    .count (out_cycle_cnt)
  );

  stat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (in_CLK),
    .rst_n (in_RST_N),
    .inc   (running & in_br_taken),
    .count (out_br_cnt)
  );

  // A jump squashed by a simultaneous taken branch is not counted.
  stat_counter #(.CNT_W(CNT_W)) u_jmp_cnt (
    .clk   (in_CLK),
    .rst_n (in_RST_N),
    .inc   (running & in_jmp & ~in_br_taken),
    .count (out_jmp_cnt)
  );

endmodule
